// File: rtl/uart_rx_framed.sv
// UART receiver with input synchroniser, optional parity, 1/2 stop bits, false-start
// rejection and a valid/ready holding register that assembles W_OUT-bit words.
module uart_rx_framed #(
  parameter int unsigned CLOCKS_PER_PULSE = 4,
  parameter int unsigned BITS_PER_WORD    = 8,
  parameter int unsigned W_OUT            = 16,
  parameter int unsigned PARITY           = 0,
  parameter int unsigned STOP_BITS        = 1,
  parameter int unsigned SYNC_STAGES      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic             m_ready,
  output logic             m_valid,
  output logic [W_OUT-1:0] m_data,
  output logic             m_frame_err,
  output logic             m_parity_err,
  output logic             overflow
);

  localparam int unsigned NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int unsigned HALF      = CLOCKS_PER_PULSE / 2;
  localparam int unsigned CW        = $clog2(CLOCKS_PER_PULSE);
  localparam int unsigned BW        = $clog2(BITS_PER_WORD + 1);
  localparam int unsigned WW        = $clog2(NUM_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]      r_cnt;
  logic [BW-1:0]      r_bit;
  logic [WW-1:0]      r_char;
  logic [W_OUT-1:0]   r_word;
  logic               r_par;
  logic               r_perr;
  logic               r_ferr;
  logic               r_stop_bad;
  logic               w_rxs;
  logic               w_tc;
  logic               w_char_done;
  logic               w_word_done;
  logic               w_last_bit;
  logic               w_last_stop;
  logic               w_par_bad;
  logic               w_load;

  // Metastability guard on the asynchronous line; idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
  end

  assign w_rxs       = r_sync[SYNC_STAGES-1];
  assign w_last_bit  = (r_bit == BW'(BITS_PER_WORD - 1));
  assign w_last_stop = (r_bit == BW'(STOP_BITS - 1));
  assign w_par_bad   = (PARITY == 2) ? (r_par ^ w_rxs) : ~(r_par ^ w_rxs);
  assign w_word_done = w_char_done && (r_char == WW'(NUM_WORDS - 1));
  assign w_load      = w_word_done && (!m_valid || m_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_tc        = 1'b0;
    w_char_done = 1'b0;
    case (r_state)
      S_IDLE: if (!w_rxs) w_next = S_START;
      S_START: begin
        w_tc = (r_cnt == CW'(HALF - 1));
        if (w_tc) w_next = w_rxs ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        w_tc = (r_cnt == CW'(CLOCKS_PER_PULSE - 1));
        if (w_tc && w_last_bit) w_next = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        w_tc = (r_cnt == CW'(CLOCKS_PER_PULSE - 1));
        if (w_tc) w_next = S_STOP;
      end
      S_STOP: begin
        w_tc = (r_cnt == CW'(CLOCKS_PER_PULSE - 1));
        if (w_tc && w_last_stop) begin
          w_char_done = 1'b1;
          w_next      = (r_stop_bad || !w_rxs) ? S_BREAK : S_IDLE;
        end
      end
      S_BREAK: if (w_rxs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: data bits shift straight into the word so the first character ends up lowest
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_bit        <= '0;
      r_char       <= '0;
      r_word       <= '0;
      r_par        <= 1'b0;
      r_perr       <= 1'b0;
      r_ferr       <= 1'b0;
      r_stop_bad   <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_frame_err  <= 1'b0;
      m_parity_err <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      r_cnt <= (w_tc || r_state == S_IDLE || r_state == S_BREAK) ? '0 : r_cnt + CW'(1);
      case (r_state)
        S_IDLE, S_BREAK: begin
          r_bit      <= '0;
          r_par      <= 1'b0;
          r_stop_bad <= 1'b0;
        end
        S_DATA: if (w_tc) begin
          r_word <= {w_rxs, r_word[W_OUT-1:1]};
          r_par  <= r_par ^ w_rxs;
          r_bit  <= w_last_bit ? '0 : r_bit + BW'(1);
        end
        S_PARITY: if (w_tc && w_par_bad) r_perr <= 1'b1;
        S_STOP: if (w_tc) begin
          if (!w_rxs) begin
            r_stop_bad <= 1'b1;
            r_ferr     <= 1'b1;
          end
          r_bit <= w_last_stop ? '0 : r_bit + BW'(1);
        end
        default: ;
      endcase
      if (w_char_done) r_char <= w_word_done ? '0 : r_char + WW'(1);
      if (w_word_done) begin
        r_ferr <= 1'b0;
        r_perr <= 1'b0;
      end
      // Holding register: load when free or draining this cycle, else drop and flag
      overflow <= 1'b0;
      if (w_load) begin
        m_valid      <= 1'b1;
        m_data       <= r_word;
        m_frame_err  <= r_ferr | ~w_rxs;
        m_parity_err <= r_perr;
      end else if (w_word_done) begin
        overflow <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: P=4, 8-bit chars, 16-bit words, even parity, 1 stop.
module tb_uart_rx_framed;

  localparam int unsigned P = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        m_ready;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_frame_err;
  logic        m_parity_err;
  logic        overflow;

  int total = 0;
  int bad   = 0;
  int n_xfer;
  int n_ovf;
  logic [15:0] last_data;
  logic        last_fe;
  logic        last_pe;

  uart_rx_framed #(
    .CLOCKS_PER_PULSE(P),
    .BITS_PER_WORD(8),
    .W_OUT(16),
    .PARITY(2),
    .STOP_BITS(1),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .m_ready(m_ready),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_frame_err(m_frame_err),
    .m_parity_err(m_parity_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Record accepted words and overflow pulses mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        n_xfer    = n_xfer + 1;
        last_data = m_data;
        last_fe   = m_frame_err;
        last_pe   = m_parity_err;
      end
      if (overflow) n_ovf = n_ovf + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    n_xfer    = 0;
    n_ovf     = 0;
    last_data = 16'h0;
    last_fe   = 1'b0;
    last_pe   = 1'b0;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (P) @(negedge clk);
  endtask

  task automatic send_char(input logic [7:0] d, input logic par, input logic stp);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stp);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_mon();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
    total++; if (m_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", m_data); end
    total++; if (m_frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", m_frame_err); end
    total++; if (m_parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", m_parity_err); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_basic();
    clear_mon();
    send_char(8'hA5, 1'b0, 1'b1);
    send_char(8'h3C, 1'b0, 1'b1);
    idle(8);
    total++; if (n_xfer !== 1) begin bad++; $display("FAIL basic_count got=%0d exp=1", n_xfer); end
    total++; if (last_data !== 16'h3CA5) begin bad++; $display("FAIL basic_data got=%h exp=3ca5", last_data); end
    total++; if (last_fe !== 1'b0) begin bad++; $display("FAIL basic_ferr got=%b exp=0", last_fe); end
    total++; if (last_pe !== 1'b0) begin bad++; $display("FAIL basic_perr got=%b exp=0", last_pe); end
    total++; if (n_ovf !== 0) begin bad++; $display("FAIL basic_ovf got=%0d exp=0", n_ovf); end
  endtask

  task automatic test_parity();
    clear_mon();
    send_char(8'h01, 1'b0, 1'b1);
    send_char(8'h00, 1'b0, 1'b1);
    idle(8);
    total++; if (n_xfer !== 1) begin bad++; $display("FAIL par_count got=%0d exp=1", n_xfer); end
    total++; if (last_data !== 16'h0001) begin bad++; $display("FAIL par_data got=%h exp=0001", last_data); end
    total++; if (last_pe !== 1'b1) begin bad++; $display("FAIL par_perr got=%b exp=1", last_pe); end
    total++; if (last_fe !== 1'b0) begin bad++; $display("FAIL par_ferr got=%b exp=0", last_fe); end
  endtask

  task automatic test_framing();
    clear_mon();
    send_char(8'h55, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    idle(8);
    total++; if (n_xfer !== 0) begin bad++; $display("FAIL frame_hold_count got=%0d exp=0", n_xfer); end
    send_char(8'h11, 1'b0, 1'b1);
    idle(8);
    total++; if (n_xfer !== 1) begin bad++; $display("FAIL frame_count got=%0d exp=1", n_xfer); end
    total++; if (last_data !== 16'h1155) begin bad++; $display("FAIL frame_data got=%h exp=1155", last_data); end
    total++; if (last_fe !== 1'b1) begin bad++; $display("FAIL frame_ferr got=%b exp=1", last_fe); end
    total++; if (last_pe !== 1'b0) begin bad++; $display("FAIL frame_perr got=%b exp=0", last_pe); end
    send_char(8'h22, 1'b0, 1'b1);
    send_char(8'h33, 1'b0, 1'b1);
    idle(8);
    total++; if (n_xfer !== 2) begin bad++; $display("FAIL frame2_count got=%0d exp=2", n_xfer); end
    total++; if (last_data !== 16'h3322) begin bad++; $display("FAIL frame2_data got=%h exp=3322", last_data); end
    total++; if (last_fe !== 1'b0) begin bad++; $display("FAIL frame2_ferr got=%b exp=0", last_fe); end
    total++; if (last_pe !== 1'b0) begin bad++; $display("FAIL frame2_perr got=%b exp=0", last_pe); end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx = 1'b0;
    @(negedge clk);
    idle(20);
    total++; if (n_xfer !== 0) begin bad++; $display("FAIL glitch_count got=%0d exp=0", n_xfer); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL glitch_valid got=%b exp=0", m_valid); end
    send_char(8'hC3, 1'b0, 1'b1);
    send_char(8'h5A, 1'b0, 1'b1);
    idle(8);
    total++; if (n_xfer !== 1) begin bad++; $display("FAIL glitch_after_count got=%0d exp=1", n_xfer); end
    total++; if (last_data !== 16'h5AC3) begin bad++; $display("FAIL glitch_after_data got=%h exp=5ac3", last_data); end
  endtask

  task automatic test_overflow();
    clear_mon();
    m_ready = 1'b0;
    send_char(8'h34, 1'b1, 1'b1);
    send_char(8'h12, 1'b0, 1'b1);
    idle(8);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL ovf_hold_valid got=%b exp=1", m_valid); end
    total++; if (m_data !== 16'h1234) begin bad++; $display("FAIL ovf_hold_data got=%h exp=1234", m_data); end
    send_char(8'h78, 1'b0, 1'b1);
    send_char(8'h56, 1'b0, 1'b1);
    idle(8);
    total++; if (n_ovf !== 1) begin bad++; $display("FAIL ovf_pulses got=%0d exp=1", n_ovf); end
    total++; if (m_data !== 16'h1234) begin bad++; $display("FAIL ovf_kept_data got=%h exp=1234", m_data); end
    total++; if (n_xfer !== 0) begin bad++; $display("FAIL ovf_no_xfer got=%0d exp=0", n_xfer); end
    @(posedge clk);
    #1 m_ready = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (n_xfer !== 1) begin bad++; $display("FAIL ovf_drain_count got=%0d exp=1", n_xfer); end
    total++; if (last_data !== 16'h1234) begin bad++; $display("FAIL ovf_drain_data got=%h exp=1234", last_data); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL ovf_drain_valid got=%b exp=0", m_valid); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    send_char(8'h11, 1'b0, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx  = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(4);
    send_char(8'hEF, 1'b1, 1'b1);
    send_char(8'hBE, 1'b0, 1'b1);
    idle(8);
    total++; if (n_xfer !== 1) begin bad++; $display("FAIL rstmid_count got=%0d exp=1", n_xfer); end
    total++; if (last_data !== 16'hBEEF) begin bad++; $display("FAIL rstmid_data got=%h exp=beef", last_data); end
    total++; if (last_fe !== 1'b0) begin bad++; $display("FAIL rstmid_ferr got=%b exp=0", last_fe); end
    total++; if (last_pe !== 1'b0) begin bad++; $display("FAIL rstmid_perr got=%b exp=0", last_pe); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_glitch();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_framed.md
# uart_rx_framed

Parametrised UART receiver: successor to the basic 8N1 word-assembling receiver. Adds an input synchroniser, optional parity, one or two stop bits, false-start rejection, per-word framing/parity error flags, and a valid/ready output holding register with overflow reporting. Sits between the board RX pin and the matrix-vector engine's input stream, assembling `W_OUT`-bit words from consecutive UART characters.

## Interface
- `CLOCKS_PER_PULSE`, 4: clk cycles per UART bit; even, ≥ 4.
- `BITS_PER_WORD`, 8: data bits per character, 5..9.
- `W_OUT`, 16: output word width; integer multiple of `BITS_PER_WORD`.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `SYNC_STAGES`, 2: rx synchroniser depth, ≥ 2.

- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx` in 1: asynchronous serial line, idle high.
- `m_ready` in 1: downstream accepts the word.
- `m_valid` out 1: `m_data` and flags valid.
- `m_data` out `W_OUT`: assembled word.
- `m_frame_err` out 1: some character in this word had a stop bit sampled 0.
- `m_parity_err` out 1: some character in this word failed parity (always 0 when `PARITY`=0).
- `overflow` out 1: one-cycle pulse when a completed word is dropped.

## Operation
- `rx` passes through `SYNC_STAGES` flops (reset to 1); all logic uses the synchronised `rxs`.
- NUM_WORDS = `W_OUT`/`BITS_PER_WORD`. Bits are LSB first. The first character lands in `m_data[BITS_PER_WORD-1:0]`.
- State machine:
  - IDLE: when `rxs`=0, go to START with the clock counter cleared.
  - START: count `CLOCKS_PER_PULSE`/2 cycles, then sample. If `rxs`=1, it is a false start: go to IDLE. Otherwise go to DATA.
  - DATA: sample every `CLOCKS_PER_PULSE` cycles and shift into the internal shift register. After `BITS_PER_WORD` samples go to PARITY if `PARITY`≠0, else STOP.
  - PARITY: sample once after `CLOCKS_PER_PULSE` cycles. Compare with XOR of the character's data bits (even: XOR equals bit; odd: XOR differs). On mismatch set the internal parity flag.
  - STOP: take `STOP_BITS` samples, `CLOCKS_PER_PULSE` apart. Any 0 sets the internal framing flag.
    - If the character is the last of the word, run completion (below).
    - If any stop sample was 0, go to BREAK, else IDLE.
  - BREAK: wait until `rxs`=1, then go to IDLE. No start detection while in BREAK.
- Completion:
  - If the output register is empty, or is being handshaken this cycle (`m_valid`&`m_ready`): load `m_data` from the shift register, load both flags, set `m_valid`.
  - Otherwise drop the word, pulse `overflow`, and leave the held word untouched.
  - In both cases clear the internal flags and the character counter.
- Output register: `m_valid` stays high, and `m_data` and flags stay stable, until a cycle with `m_ready`=1. `m_valid` falls the next cycle unless a new word is loaded in the same cycle.
- Errored words are still delivered; the flags mark them.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_frame_err`=0, `m_parity_err`=0, `overflow`=0. State IDLE, all counters 0, internal flags 0.
- Reset mid-frame discards the partial word and any held word.
- Let t0 be the first cycle IDLE sees `rxs`=0, i.e. `SYNC_STAGES` cycles after the `rx` falling edge:
  - start sample at t0+P/2;
  - data bit k at t0+P/2+(k+1)·P;
  - parity and stop bits follow at P spacing.
- `m_valid` rises one cycle after the last stop sample of the last character. `overflow` pulses in that same cycle.
- Back-to-back characters need no idle time: IDLE may detect the next start on the cycle after the final stop sample.
- A low glitch shorter than P/2 cycles produces no data and no flags.
- Counter widths are `$clog2` of each range, plus 1 bit where the terminal count equals a power of two.

## Test plan
Bench parameters: P=4, `BITS_PER_WORD`=8, `W_OUT`=16, `PARITY`=2, `STOP_BITS`=1, `m_ready`=1 unless noted.
- Send 0xA5 then 0x3C with correct parity → one `m_valid` pulse, `m_data`=0x3CA5, both error flags 0, no `overflow`.
- Send 0x01 with parity bit 0, then 0x00 with parity bit 0 → `m_data`=0x0001, `m_parity_err`=1, `m_frame_err`=0.
- Send 0x55 with stop bit 0, then hold `rx` low 40 cycles, release, send 0x11 and 0x22 → first word completes only after 0x11: `m_data`=0x1155, `m_frame_err`=1. No words arise during the low hold. Then `m_data`=0x..22 on the next word with flags clear.
- Pulse `rx` low for 1 cycle, then idle 20 cycles → no `m_valid`; FSM back in IDLE.
- With `m_ready`=0, send 0x1234 then 0x5678:
  - `m_data` holds 0x1234 with `m_valid`=1;
  - `overflow` pulses once at the second completion;
  - after raising `m_ready`, a single transfer of 0x1234, then `m_valid`=0.
- Assert `rst` midway through the second character of a word, release, send 0xBEEF as two characters → `m_data`=0xBEEF, flags 0; the partial word is never output.
